// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
//   Shared types and constants for the core pipeline.
//
//   FETCH_BUF_DEPTH : depth of the fetch buffer instantiated by the core top.
//   fetch_entry_t   : one fetched instruction word as it travels from the
//                     fetch interface to decode (PC, instruction, fault flag).
// ----------------------------------------------------------------------------
package core_pkg;

  localparam int FETCH_BUF_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/core_fetch_buffer.sv
// ----------------------------------------------------------------------------
// core_fetch_buffer
//   Decoupling FIFO between the instruction-fetch memory interface and the
//   decode stage. Words leave in the order they arrived, each carrying its own
//   access-fault flag. A flush empties the buffer and drops the same-cycle
//   input word.
//
//   Optional feature macro: CORE_FETCH_BYPASS_EN
//     When defined, an incoming word presented to an empty buffer is shown to
//     decode in the same cycle; if decode takes it, it is never stored.
//
// Ports
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        discard all entries and the same-cycle input word
//   fetch_valid  upstream word valid
//   fetch_ready  buffer can accept a word (not full)
//   fetch_pc     PC of incoming word
//   fetch_instr  incoming instruction word
//   fetch_err    access fault for incoming word
//   dec_valid    head entry valid for decode
//   dec_ready    decoder consumes head this cycle
//   dec_pc       PC of head entry
//   dec_instr    instruction of head entry
//   dec_err      fault flag of head entry
//   count        number of stored entries
// ----------------------------------------------------------------------------
module core_fetch_buffer
  import core_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [31:0]                fetch_pc,
  input  logic [31:0]                fetch_instr,
  input  logic                       fetch_err,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_pc,
  output logic [31:0]                dec_instr,
  output logic                       dec_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate counter.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  logic         empty;
  logic         full;
  logic         push;
  logic         pop;
  fetch_entry_t in_entry;
  fetch_entry_t head_entry;
  fetch_entry_t out_entry;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_idx == rd_idx) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

  // Deliberately independent of dec_ready: a full buffer refuses input even if
  // the head is popped in the same cycle, keeping fetch_ready free of a
  // decode-to-fetch combinational path.
  assign fetch_ready = !full;

  assign in_entry.pc    = fetch_pc;
  assign in_entry.instr = fetch_instr;
  assign in_entry.err   = fetch_err;

  assign head_entry = mem[rd_idx];

`ifdef CORE_FETCH_BYPASS_EN
  // An empty buffer with a live input word forwards it straight to decode.
  // If decode accepts it the word is consumed here and never written.
  logic bypass_active;

  assign bypass_active = empty && fetch_valid && !flush;

  assign dec_valid = (!empty || bypass_active) && !flush;
  assign out_entry = bypass_active ? in_entry : head_entry;
  assign push      = fetch_valid && !full && !flush && !(bypass_active && dec_ready);
  assign pop       = !empty && dec_ready && !flush;
`else
  assign dec_valid = !empty && !flush;
  assign out_entry = head_entry;
  assign push      = fetch_valid && !full && !flush;
  assign pop       = dec_valid && dec_ready;
`endif

  assign dec_pc    = out_entry.pc;
  assign dec_instr = out_entry.instr;
  assign dec_err   = out_entry.err;

  // Occupancy is the modular pointer distance; with a power-of-two depth the
  // pointer width and count width coincide.
  assign count = CNT_W'(wr_ptr - rd_ptr);

  // Pointer update. Flush wins over push and pop: collapsing the read pointer
  // onto the write pointer empties the buffer in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage is cleared on reset so the data outputs read zero while empty
  // after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_idx] <= in_entry;
    end
  end

endmodule

// File: tb/tb_core_fetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_core_fetch_buffer
//   Self-checking bench for core_fetch_buffer. A queue-based reference model
//   tracks the expected contents; a compare process checks every output on
//   each falling edge, and directed sections pin literal values.
//   Follows CORE_FETCH_BYPASS_EN when defined.
// ----------------------------------------------------------------------------
module tb_core_fetch_buffer;
  import core_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             fetch_valid;
  logic             fetch_ready;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_instr;
  logic             fetch_err;
  logic             dec_valid;
  logic             dec_ready;
  logic [31:0]      dec_pc;
  logic [31:0]      dec_instr;
  logic             dec_err;
  logic [CNT_W-1:0] count;

  int total;
  int bad;

  fetch_entry_t model_q [$];

  core_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .fetch_err   (fetch_err),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .dec_err     (dec_err),
    .count       (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic err, input logic rdy, input logic fl);
    fetch_valid = v;
    fetch_pc    = pc;
    fetch_instr = instr;
    fetch_err   = err;
    dec_ready   = rdy;
    flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of at most DEPTH words. Acceptance depends on
  // occupancy before the edge, so a full buffer refuses input even while
  // its head is being consumed.
  always @(posedge clk or negedge rst_n) begin : model_update
    bit do_push;
    bit do_pop;
    bit bypassed;
    fetch_entry_t e;
    if (!rst_n) begin
      model_q.delete();
    end else if (!flush) begin
      bypassed = 1'b0;
`ifdef CORE_FETCH_BYPASS_EN
      if (model_q.size() == 0 && fetch_valid && dec_ready) bypassed = 1'b1;
`endif
      if (!bypassed) begin
        do_push = fetch_valid && (model_q.size() < DEPTH);
        do_pop  = (model_q.size() > 0) && dec_ready;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
          e.pc    = fetch_pc;
          e.instr = fetch_instr;
          e.err   = fetch_err;
          model_q.push_back(e);
        end
      end
    end else begin
      model_q.delete();
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin : compare
    bit exp_valid;
    fetch_entry_t e;
    if (rst_n) begin
      exp_valid = (model_q.size() > 0) && !flush;
      e = '0;
      if (model_q.size() > 0) e = model_q[0];
`ifdef CORE_FETCH_BYPASS_EN
      if (model_q.size() == 0 && fetch_valid && !flush) begin
        exp_valid = 1'b1;
        e.pc    = fetch_pc;
        e.instr = fetch_instr;
        e.err   = fetch_err;
      end
`endif
      checkOutput("cyc_dec_valid", 32'(dec_valid), 32'(exp_valid));
      checkOutput("cyc_count", 32'(count), 32'(model_q.size()));
      checkOutput("cyc_fetch_ready", 32'(fetch_ready), 32'(model_q.size() < DEPTH));
      if (exp_valid) begin
        checkOutput("cyc_dec_pc", dec_pc, e.pc);
        checkOutput("cyc_dec_instr", dec_instr, e.instr);
        checkOutput("cyc_dec_err", 32'(dec_err), 32'(e.err));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #12;

    // Reset values
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_dec_valid", 32'(dec_valid), 32'd0);
    checkOutput("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    checkOutput("rst_dec_pc", dec_pc, 32'd0);
    checkOutput("rst_dec_instr", dec_instr, 32'd0);
    checkOutput("rst_dec_err", 32'(dec_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single word latency
    applyStimulus(1'b1, 32'h100, 32'h13, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef CORE_FETCH_BYPASS_EN
    checkOutput("bypass_same_cycle_valid", 32'(dec_valid), 32'd1);
    checkOutput("bypass_same_cycle_pc", dec_pc, 32'h100);
`else
    checkOutput("no_bypass_same_cycle_valid", 32'(dec_valid), 32'd0);
`endif
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("lat_dec_valid", 32'(dec_valid), 32'd1);
    checkOutput("lat_dec_pc", dec_pc, 32'h100);
    checkOutput("lat_dec_instr", dec_instr, 32'h13);
    checkOutput("lat_count", 32'(count), 32'd1);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    checkOutput("lat_drained", 32'(count), 32'd0);

    // Fill to full, hold a fifth word, then drain in order
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    checkOutput("full_fetch_ready", 32'(fetch_ready), 32'd0);
    checkOutput("full_count", 32'(count), 32'd4);
    applyStimulus(1'b1, 32'h110, 32'h1004, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("full_held_count", 32'(count), 32'd4);
    applyStimulus(1'b1, 32'h110, 32'h1004, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("full_pop_same_cycle_ready", 32'(fetch_ready), 32'd0);
    checkOutput("drain_pc0", dec_pc, 32'h100);
    tick();
    fetch_valid = 1'b0;
    #1;
    checkOutput("full_pop_count", 32'(count), 32'd3);
    checkOutput("full_pop_ready", 32'(fetch_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      checkOutput("drain_pc", dec_pc, 32'h100 + 32'(4 * i));
      tick();
    end
    dec_ready = 1'b0;
    checkOutput("drain_empty", 32'(count), 32'd0);

    // Streaming: one word primed, then push and pop every cycle
    applyStimulus(1'b1, 32'h500, 32'h2000, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h504 + 32'(4 * i), 32'h2001 + 32'(i), 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput("stream_pc", dec_pc, 32'h500 + 32'(4 * i));
      checkOutput("stream_count", 32'(count), 32'd1);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    dec_ready = 1'b0;
    checkOutput("stream_drained", 32'(count), 32'd0);

    // Flush with three entries and a same-cycle input word
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h600 + 32'(4 * i), 32'h3000 + 32'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'h200, 32'h4000, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("flush_dec_valid", 32'(dec_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("flush_count", 32'(count), 32'd0);
    applyStimulus(1'b1, 32'h300, 32'h5000, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("post_flush_pc", dec_pc, 32'h300);
    tick();
    dec_ready = 1'b0;

    // Fault flag travels with its own word only
    applyStimulus(1'b1, 32'h3FC, 32'h6000, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h400, 32'h6001, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h404, 32'h6002, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("err_pc_a", dec_pc, 32'h3FC);
    checkOutput("err_flag_a", 32'(dec_err), 32'd0);
    tick();
    checkOutput("err_pc_b", dec_pc, 32'h400);
    checkOutput("err_flag_b", 32'(dec_err), 32'd1);
    tick();
    checkOutput("err_pc_c", dec_pc, 32'h404);
    checkOutput("err_flag_c", 32'(dec_err), 32'd0);
    tick();
    dec_ready = 1'b0;

    // Asynchronous reset pulse mid-cycle with two entries stored
    applyStimulus(1'b1, 32'h700, 32'h7000, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h704, 32'h7001, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_areset_count", 32'(count), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_count", 32'(count), 32'd0);
    checkOutput("areset_dec_valid", 32'(dec_valid), 32'd0);
    checkOutput("areset_fetch_ready", 32'(fetch_ready), 32'd1);
    checkOutput("areset_dec_instr", dec_instr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 19) == 0));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) tick();
    checkOutput("final_empty", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
